// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module reg_pipe #(
    parameter int                   DATAWIDTH   = 8,
    parameter int                   DEPTH       = 3,
    parameter logic [DATAWIDTH-1:0] RESET_VALUE = {DATAWIDTH{1'b0}}
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATAWIDTH-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATAWIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(bits[i]);
        end
        return cnt;
    endfunction

    logic [DEPTH-1:0]     v_r;
    logic [DEPTH-1:0]     adv_s;
    logic [DEPTH-1:0]     src_v_s;
    logic [DEPTH-1:0]     v_next_s;
    logic [DATAWIDTH-1:0] d_r     [DEPTH];
    logic [DATAWIDTH-1:0] src_d_s [DEPTH];
    logic [OCC_W-1:0]     occ_r;

    // Each stage's upstream source; stage 0 is fed straight from the producer.
    assign src_v_s[0] = in_valid;
    assign src_d_s[0] = in_data;
    for (genvar g = 1; g < DEPTH; g++) begin : g_src
        assign src_v_s[g] = v_r[g-1];
        assign src_d_s[g] = d_r[g-1];
    end

    // Advance chain: a stage moves if anything at or below it can drain.
    always_comb begin
        logic acc_s;
        adv_s = {DEPTH{1'b0}};
        acc_s = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc_s    = acc_s | ~v_r[i];
            adv_s[i] = acc_s;
        end
    end

    assign v_next_s = Flush ? {DEPTH{1'b0}} : ((adv_s & src_v_s) | (~adv_s & v_r));

    // Valid bits and occupancy; occupancy is the popcount of the next valid vector.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            v_r   <= {DEPTH{1'b0}};
            occ_r <= {OCC_W{1'b0}};
        end else begin
            v_r   <= v_next_s;
            occ_r <= popcount(v_next_s);
        end
    end

    // Data registers load unconditionally on advance; contents of empty stages are don't-care.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_r[i] <= RESET_VALUE;
            end
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_r[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv_s[i]) begin
                    d_r[i] <= src_d_s[i];
                end
            end
        end
    end

    // Rst_n gates in_ready so nothing is offered as accepted while held in reset.
    assign in_ready  = adv_s[0] & ~Flush & Rst_n;
    assign out_valid = v_r[DEPTH-1] & ~Flush;
    assign out_data  = d_r[DEPTH-1];
    assign occupancy = occ_r;

endmodule
